instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
- Writer side of the instruction-memory interface. The processor core only ever reads instruction memory; this block fills it.
- Accepts a byte stream over a valid/ready handshake and packs it big-endian into 32-bit instruction words.
- Writes each word into the instruction memory write port at consecutive word-aligned byte addresses.
- Holds the processor in reset (cpu_reset) for the whole load and releases it once the last word is written.

Parameters:
- Data_Width, 32, instruction/word width; must be 32.
- Addr_Width, 32, width of imem_addr, a byte address in the same format as PC.
- Depth_Words, 64, instruction memory capacity in words; maximum legal load_len.
- Base_Addr, 0, byte address of the first word written; must be a multiple of 4.
- Boot_Hold, 1, 1: cpu_reset stays high after reset until the first successful load; 0: cpu_reset drops one cycle after reset deasserts.

Ports:
- clk, input, 1, single clock, rising edge.
- reset, input, 1, synchronous, active-high.
- start, input, 1, single-cycle request to begin a load; honoured only in IDLE.
- load_len, input, 7 (clog2(Depth_Words+1)), number of words to load; sampled on start.
- abort, input, 1, cancels a load in progress.
- byte_valid, input, 1, byte_data is valid.
- byte_data, input, 8, stream byte.
- byte_ready, output, 1, loader accepts a byte this cycle.
- imem_we, output, 1, instruction memory write enable.
- imem_addr, output, Addr_Width, write byte address.
- imem_wdata, output, Data_Width, write word.
- cpu_reset, output, 1, reset to the processor core.
- busy, output, 1, load in progress.
- done, output, 1, one-cycle pulse when a load completes.
- error, output, 1, one-cycle pulse on a rejected start or on abort.

Behaviour:
- All outputs are registered.
- Reset values:
  - state = IDLE.
  - byte_ready, imem_we, busy, done, error = 0.
  - imem_addr = Base_Addr; imem_wdata = 0.
  - cpu_reset = 1.
- Reset mid-load: the load is abandoned, any partial word is discarded, and no further write is issued.
- States: IDLE, RECV, WRITE, FINISH.
- IDLE:
  - start with 1 <= load_len <= Depth_Words: latch load_len, set word index = 0, byte index = 0, imem_addr = Base_Addr, cpu_reset = 1, busy = 1; go to RECV.
  - start with load_len == 0 or load_len > Depth_Words: error pulses for 1 cycle; stay in IDLE; cpu_reset is unchanged.
- RECV:
  - byte_ready = 1.
  - A byte is accepted when byte_valid && byte_ready.
  - Byte index 0 goes to [31:24], 1 to [23:16], 2 to [15:8], 3 to [7:0].
  - On acceptance of byte 3: byte_ready drops on the next cycle and the state goes to WRITE.
- WRITE:
  - imem_we = 1 for exactly one cycle, with imem_addr and imem_wdata stable. byte_ready = 0.
  - Latency: 4th byte accepted at cycle N -> imem_we high at cycle N+1.
  - Next cycle: imem_addr += 4 and word index += 1.
  - If word index + 1 == load_len, go to FINISH; otherwise go to RECV with byte index = 0.
- FINISH: done = 1 for one cycle, busy = 0, cpu_reset = 0 on the same edge; return to IDLE.
- Throughput: at most one word per 5 cycles.
- abort in RECV:
  - Return to IDLE; error pulses; the partial word is dropped.
  - cpu_reset stays 1, because memory contents are incomplete.
  - Words already written are not rolled back.
- abort in WRITE: the write completes first; abort is then honoured on the next RECV cycle if still asserted. It is never honoured in FINISH.
- start while busy: ignored, with no error.
- byte_valid outside RECV: ignored; byte_ready is low.
- Address arithmetic: modulo 2^Addr_Width. A legal load_len never exceeds the memory, because Base_Addr + 4*Depth_Words fits.
- Boot_Hold = 0: cpu_reset goes 0 the first cycle after reset deasserts. Each accepted start re-asserts it.
- Back-to-back loads are allowed: a start in the IDLE cycle after done is accepted.

Decomposition:
- Shared package contents:
  - State encoding: IDLE = 2'd0, RECV = 2'd1, WRITE = 2'd2, FINISH = 2'd3.
  - BYTES_PER_WORD = 4.
  - ADDR_STEP = 4.
- Sub-module byte_assembler:
  - 32-bit shift register plus 2-bit byte counter.
  - Inputs: clk, reset, clear, accept, byte_data.
  - Outputs: word, word_full.
- The FSM, address counter and word counter stay in instr_mem_loader.

Test Plan:
1. Load 2 words: reset, then start with load_len=2, then stream bytes 20 08 00 05 AC 08 00 04 with byte_valid held high -> imem_we pulses twice: addr 0x0 data 0x20080005, then addr 0x4 data 0xAC080004. done pulses once; cpu_reset falls with done.
2. Valid gaps: byte_valid deasserted for 3 cycles between bytes 1 and 2 -> the word is still 0x20080005. imem_we asserts exactly 1 cycle after the 4th accepted byte.
3. Illegal length: start with load_len=0, then with load_len=65 -> error pulses each time; busy stays 0; no imem_we; cpu_reset stays 1.
4. Abort: load_len=3, abort after 1 word plus 2 bytes -> exactly one write, to 0x0; error pulses; cpu_reset stays 1. A following load_len=1 load then succeeds.
5. Reset mid-load: reset asserted during WRITE of word 2 -> next cycle imem_we=0, state IDLE, imem_addr=Base_Addr, cpu_reset=1.
6. Boot_Hold=0 plus start while busy: cpu_reset drops the cycle after reset. A second start during RECV is ignored and load_len stays at its first value.

Source files
------------

// File: rtl/instr_mem_loader_pkg.sv
// Purpose: shared types and constants for the instruction-memory loader.
// Contents: FSM state encoding, word/byte geometry, address step.
package instr_mem_loader_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RECV   = 2'd1,
      WRITE  = 2'd2,
      FINISH = 2'd3
   } state_e;

   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned ADDR_STEP      = 4;
   localparam int unsigned BYTE_W         = 8;
   localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;
   localparam int unsigned BIDX_W         = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/instr_mem_loader_byte_assembler.sv
// Purpose: packs accepted bytes big-endian into a 32-bit word.
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   clear          - drop any partial word and restart at byte 0
//   accept         - byte_data is consumed this cycle
//   byte_data      - stream byte
//   word           - assembled word (first byte lands in [31:24] after four shifts)
//   word_full      - high in the cycle the fourth byte of a word is accepted
module instr_mem_loader_byte_assembler
   import instr_mem_loader_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              accept,
   input  logic [BYTE_W-1:0] byte_data,
   output logic [WORD_W-1:0] word,
   output logic              word_full
);

   logic [BIDX_W-1:0] cnt_q;
   logic [WORD_W-1:0] word_q;

   // Left shift: after four accepts the first byte sits in the MSB lane.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         cnt_q  <= '0;
         word_q <= '0;
      end else if (accept) begin
         word_q <= {word_q[WORD_W-BYTE_W-1:0], byte_data};
         cnt_q  <= cnt_q + BIDX_W'(1);
      end
   end

   assign word      = word_q;
   assign word_full = accept && (cnt_q == BIDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instr_mem_loader.sv
// Purpose: fills instruction memory from a byte stream while holding the core in reset.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   start, load_len       - begin a load of load_len words (honoured only when idle)
//   abort                 - cancel a load while receiving bytes
//   byte_valid/byte_data  - byte stream in; byte_ready out
//   imem_we/addr/wdata    - instruction memory write port
//   cpu_reset             - processor core reset
//   busy, done, error     - load status; done/error are one-cycle pulses
module instr_mem_loader
   import instr_mem_loader_pkg::*;
#(
   parameter  int unsigned Data_Width  = 32,
   parameter  int unsigned Addr_Width  = 32,
   parameter  int unsigned Depth_Words = 64,
   parameter  int unsigned Base_Addr   = 0,
   parameter  int unsigned Boot_Hold   = 1,
   localparam int unsigned LEN_W       = $clog2(Depth_Words + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [LEN_W-1:0]      load_len,
   input  logic                  abort,
   input  logic                  byte_valid,
   input  logic [BYTE_W-1:0]     byte_data,
   output logic                  byte_ready,
   output logic                  imem_we,
   output logic [Addr_Width-1:0] imem_addr,
   output logic [Data_Width-1:0] imem_wdata,
   output logic                  cpu_reset,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   localparam logic [Addr_Width-1:0] BASE    = Addr_Width'(Base_Addr);
   localparam logic [Addr_Width-1:0] STEP    = Addr_Width'(ADDR_STEP);
   localparam logic [LEN_W-1:0]      MAX_LEN = LEN_W'(Depth_Words);

   state_e                state_q, state_d;
   logic [LEN_W-1:0]      len_q, len_d;
   logic [LEN_W-1:0]      widx_q, widx_d;
   logic [Addr_Width-1:0] addr_q, addr_d;
   logic                  ready_q, ready_d;
   logic                  we_q, we_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;
   logic                  cpu_reset_q, cpu_reset_d;
   logic                  boot_q;

   logic                  asm_clear;
   logic                  asm_accept;
   logic                  asm_full;
   logic [WORD_W-1:0]     asm_word;

   // Abort wins over a byte offered in the same cycle, so the partial word is dropped cleanly.
   assign asm_accept = (state_q == RECV) && ready_q && byte_valid && !abort;

   instr_mem_loader_byte_assembler u_asm (
      .clk       (clk),
      .reset     (reset),
      .clear     (asm_clear),
      .accept    (asm_accept),
      .byte_data (byte_data),
      .word      (asm_word),
      .word_full (asm_full)
   );

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      widx_d      = widx_q;
      addr_d      = addr_q;
      we_d        = 1'b0;
      done_d      = 1'b0;
      error_d     = 1'b0;
      busy_d      = busy_q;
      cpu_reset_d = cpu_reset_q;
      asm_clear   = 1'b0;

      // Without boot hold the core is released on the first cycle out of reset.
      if ((Boot_Hold == 0) && boot_q) cpu_reset_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               if ((load_len != '0) && (load_len <= MAX_LEN)) begin
                  state_d     = RECV;
                  len_d       = load_len;
                  widx_d      = '0;
                  addr_d      = BASE;
                  cpu_reset_d = 1'b1;
                  busy_d      = 1'b1;
                  asm_clear   = 1'b1;
               end else begin
                  error_d = 1'b1;
               end
            end
         end
         RECV: begin
            // Core stays in reset after abort: memory contents are incomplete.
            if (abort) begin
               state_d   = IDLE;
               busy_d    = 1'b0;
               error_d   = 1'b1;
               asm_clear = 1'b1;
            end else if (asm_full) begin
               state_d = WRITE;
               we_d    = 1'b1;
            end
         end
         WRITE: begin
            addr_d = addr_q + STEP;
            widx_d = widx_q + LEN_W'(1);
            if (widx_d == len_q) begin
               state_d     = FINISH;
               busy_d      = 1'b0;
               done_d      = 1'b1;
               cpu_reset_d = 1'b0;
            end else begin
               state_d = RECV;
            end
         end
         FINISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      ready_d = (state_d == RECV);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         len_q       <= '0;
         widx_q      <= '0;
         addr_q      <= BASE;
         ready_q     <= 1'b0;
         we_q        <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         cpu_reset_q <= 1'b1;
         boot_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         widx_q      <= widx_d;
         addr_q      <= addr_d;
         ready_q     <= ready_d;
         we_q        <= we_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
         cpu_reset_q <= cpu_reset_d;
         boot_q      <= 1'b0;
      end
   end

   assign byte_ready = ready_q;
   assign imem_we    = we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = Data_Width'(asm_word);
   assign cpu_reset  = cpu_reset_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = error_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Purpose: directed self-checking bench for instr_mem_loader.
// A second instance with Boot_Hold=0 shares all inputs; only its cpu_reset is observed.
module tb_instr_mem_loader;

   logic        clk = 1'b0;
   logic        reset, start, abort, byte_valid;
   logic [6:0]  load_len;
   logic [7:0]  byte_data;
   logic        byte_ready, imem_we, cpu_reset, busy, done, error;
   logic [31:0] imem_addr, imem_wdata;
   logic        nb_byte_ready, nb_imem_we, nb_cpu_reset, nb_busy, nb_done, nb_error;
   logic [31:0] nb_imem_addr, nb_imem_wdata;

   int pass_cnt = 0;
   int total_cnt = 0;
   int wr_cnt = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   logic [31:0] wr_addr [64];
   logic [31:0] wr_data [64];

   always #5 clk = ~clk;

   instr_mem_loader #(.Boot_Hold(1)) dut (
      .clk(clk), .reset(reset), .start(start), .load_len(load_len), .abort(abort),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
   );

   instr_mem_loader #(.Boot_Hold(0)) dut_nb (
      .clk(clk), .reset(reset), .start(start), .load_len(load_len), .abort(abort),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(nb_byte_ready),
      .imem_we(nb_imem_we), .imem_addr(nb_imem_addr), .imem_wdata(nb_imem_wdata),
      .cpu_reset(nb_cpu_reset), .busy(nb_busy), .done(nb_done), .error(nb_error)
   );

   // Write / pulse log of the main instance.
   always @(posedge clk) begin
      if (imem_we) begin
         if (wr_cnt < 64) begin
            wr_addr[wr_cnt] <= imem_addr;
            wr_data[wr_cnt] <= imem_wdata;
         end
         wr_cnt <= wr_cnt + 1;
      end
      if (done)  done_cnt <= done_cnt + 1;
      if (error) err_cnt  <= err_cnt + 1;
   end

   // Offer one byte from a negedge; returns on the negedge after it is accepted.
   task automatic send_byte(input logic [7:0] b);
      bit got = 1'b0;
      byte_valid = 1'b1;
      byte_data  = b;
      for (int i = 0; i < 20 && !got; i++) begin
         got = (byte_ready === 1'b1);
         @(negedge clk);
      end
      if (!got) begin
         total_cnt++;
         $display("FAIL send_byte_timeout byte=%02h got byte_ready=%b need 1", b, byte_ready);
      end
   endtask

   task automatic send_word(input logic [31:0] w);
      send_byte(w[31:24]);
      send_byte(w[23:16]);
      send_byte(w[15:8]);
      send_byte(w[7:0]);
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; abort = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; load_len = 7'd0;
      repeat (2) @(negedge clk);
      total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else pass_cnt++;
      total_cnt++; if (byte_ready !== 1'b0) $display("FAIL rst_ready got %b exp 0", byte_ready); else pass_cnt++;
      total_cnt++; if (imem_we !== 1'b0) $display("FAIL rst_we got %b exp 0", imem_we); else pass_cnt++;
      total_cnt++; if (done !== 1'b0 || error !== 1'b0) $display("FAIL rst_pulses got %b%b exp 00", done, error); else pass_cnt++;
      total_cnt++; if (imem_addr !== 32'h0) $display("FAIL rst_addr got %h exp 0", imem_addr); else pass_cnt++;
      total_cnt++; if (imem_wdata !== 32'h0) $display("FAIL rst_wdata got %h exp 0", imem_wdata); else pass_cnt++;
      total_cnt++; if (cpu_reset !== 1'b1) $display("FAIL rst_cpu_reset got %b exp 1", cpu_reset); else pass_cnt++;
      total_cnt++; if (nb_cpu_reset !== 1'b1) $display("FAIL rst_nb_cpu_reset got %b exp 1", nb_cpu_reset); else pass_cnt++;
      reset = 1'b0;
      @(negedge clk);
      total_cnt++; if (cpu_reset !== 1'b1) $display("FAIL boot_hold got %b exp 1", cpu_reset); else pass_cnt++;
      total_cnt++; if (nb_cpu_reset !== 1'b0) $display("FAIL no_boot_hold got %b exp 0", nb_cpu_reset); else pass_cnt++;
   endtask

   task automatic test_illegal_len();
      int w0 = wr_cnt;
      int e0 = err_cnt;
      start = 1'b1; load_len = 7'd0;
      @(negedge clk);
      start = 1'b0;
      total_cnt++; if (error !== 1'b1) $display("FAIL len0_error got %b exp 1", error); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL len0_busy got %b exp 0", busy); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (error !== 1'b0) $display("FAIL len0_pulse got %b exp 0", error); else pass_cnt++;
      start = 1'b1; load_len = 7'd65;
      @(negedge clk);
      start = 1'b0;
      total_cnt++; if (error !== 1'b1) $display("FAIL len65_error got %b exp 1", error); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0 || byte_ready !== 1'b0) $display("FAIL len65_busy got %b%b exp 00", busy, byte_ready); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (wr_cnt - w0 != 0) $display("FAIL illegal_writes got %0d exp 0", wr_cnt - w0); else pass_cnt++;
      total_cnt++; if (err_cnt - e0 != 2) $display("FAIL illegal_errors got %0d exp 2", err_cnt - e0); else pass_cnt++;
      total_cnt++; if (cpu_reset !== 1'b1) $display("FAIL illegal_cpu_reset got %b exp 1", cpu_reset); else pass_cnt++;
   endtask

   task automatic test_two_words();
      int w0 = wr_cnt;
      int d0 = done_cnt;
      start = 1'b1; load_len = 7'd2;
      @(negedge clk);
      start = 1'b0;
      total_cnt++; if (busy !== 1'b1 || byte_ready !== 1'b1) $display("FAIL tw_start got busy=%b ready=%b exp 11", busy, byte_ready); else pass_cnt++;
      send_word(32'h20080005);
      total_cnt++; if (imem_we !== 1'b1 || imem_addr !== 32'h0 || imem_wdata !== 32'h20080005)
         $display("FAIL tw_w0 got we=%b a=%h d=%h exp 1/0/20080005", imem_we, imem_addr, imem_wdata); else pass_cnt++;
      send_word(32'hAC080004);
      byte_valid = 1'b0;
      total_cnt++; if (imem_we !== 1'b1 || imem_addr !== 32'h4 || imem_wdata !== 32'hAC080004)
         $display("FAIL tw_w1 got we=%b a=%h d=%h exp 1/4/ac080004", imem_we, imem_addr, imem_wdata); else pass_cnt++;
      total_cnt++; if (cpu_reset !== 1'b1) $display("FAIL tw_hold got %b exp 1", cpu_reset); else pass_cnt++;
      for (int i = 0; i < 30 && done !== 1'b1; i++) @(negedge clk);
      total_cnt++; if (done !== 1'b1) $display("FAIL tw_done got %b exp 1", done); else pass_cnt++;
      total_cnt++; if (cpu_reset !== 1'b0 || busy !== 1'b0) $display("FAIL tw_release got cpu_reset=%b busy=%b exp 00", cpu_reset, busy); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (wr_cnt - w0 != 2) $display("FAIL tw_writes got %0d exp 2", wr_cnt - w0); else pass_cnt++;
      total_cnt++; if (done_cnt - d0 != 1) $display("FAIL tw_done_count got %0d exp 1", done_cnt - d0); else pass_cnt++;
   endtask

   task automatic test_valid_gaps();
      start = 1'b1; load_len = 7'd1;
      @(negedge clk);
      start = 1'b0;
      total_cnt++; if (cpu_reset !== 1'b1) $display("FAIL gap_reassert got %b exp 1", cpu_reset); else pass_cnt++;
      send_byte(8'h20);
      send_byte(8'h08);
      byte_valid = 1'b0;
      repeat (3) @(negedge clk);
      total_cnt++; if (byte_ready !== 1'b1 || imem_we !== 1'b0) $display("FAIL gap_idle got ready=%b we=%b exp 10", byte_ready, imem_we); else pass_cnt++;
      send_byte(8'h00);
      total_cnt++; if (imem_we !== 1'b0) $display("FAIL gap_early_we got %b exp 0", imem_we); else pass_cnt++;
      send_byte(8'h05);
      byte_valid = 1'b0;
      total_cnt++; if (imem_we !== 1'b1 || imem_wdata !== 32'h20080005 || imem_addr !== 32'h0)
         $display("FAIL gap_word got we=%b a=%h d=%h exp 1/0/20080005", imem_we, imem_addr, imem_wdata); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (imem_we !== 1'b0 || done !== 1'b1) $display("FAIL gap_finish got we=%b done=%b exp 01", imem_we, done); else pass_cnt++;
      @(negedge clk);
   endtask

   task automatic test_abort();
      int w0 = wr_cnt;
      int e0 = err_cnt;
      start = 1'b1; load_len = 7'd3;
      @(negedge clk);
      start = 1'b0;
      send_word(32'h11223344);
      send_byte(8'h55);
      send_byte(8'h66);
      byte_valid = 1'b0;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      total_cnt++; if (error !== 1'b1 || busy !== 1'b0 || byte_ready !== 1'b0)
         $display("FAIL abort_state got err=%b busy=%b ready=%b exp 100", error, busy, byte_ready); else pass_cnt++;
      total_cnt++; if (cpu_reset !== 1'b1) $display("FAIL abort_cpu_reset got %b exp 1", cpu_reset); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (wr_cnt - w0 != 1) $display("FAIL abort_writes got %0d exp 1", wr_cnt - w0); else pass_cnt++;
      total_cnt++; if (wr_addr[w0] !== 32'h0 || wr_data[w0] !== 32'h11223344)
         $display("FAIL abort_word got a=%h d=%h exp 0/11223344", wr_addr[w0], wr_data[w0]); else pass_cnt++;
      total_cnt++; if (err_cnt - e0 != 1) $display("FAIL abort_errors got %0d exp 1", err_cnt - e0); else pass_cnt++;
      start = 1'b1; load_len = 7'd1;
      @(negedge clk);
      start = 1'b0;
      send_word(32'h01020304);
      byte_valid = 1'b0;
      total_cnt++; if (imem_we !== 1'b1 || imem_addr !== 32'h0 || imem_wdata !== 32'h01020304)
         $display("FAIL reload_word got we=%b a=%h d=%h exp 1/0/01020304", imem_we, imem_addr, imem_wdata); else pass_cnt++;
      for (int i = 0; i < 30 && done !== 1'b1; i++) @(negedge clk);
      total_cnt++; if (done !== 1'b1 || cpu_reset !== 1'b0) $display("FAIL reload_done got done=%b cpu_reset=%b exp 10", done, cpu_reset); else pass_cnt++;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int w0 = wr_cnt;
      int e0 = err_cnt;
      start = 1'b1; load_len = 7'd2;
      @(negedge clk);
      load_len = 7'd1;
      @(negedge clk);
      start = 1'b0;
      send_word(32'hA1A2A3A4);
      send_word(32'hB1B2B3B4);
      byte_valid = 1'b0;
      for (int i = 0; i < 30 && done !== 1'b1; i++) @(negedge clk);
      total_cnt++; if (done !== 1'b1) $display("FAIL busy_start_done got %b exp 1", done); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (wr_cnt - w0 != 2) $display("FAIL busy_start_writes got %0d exp 2", wr_cnt - w0); else pass_cnt++;
      total_cnt++; if (wr_addr[w0 + 1] !== 32'h4 || wr_data[w0 + 1] !== 32'hB1B2B3B4)
         $display("FAIL busy_start_w1 got a=%h d=%h exp 4/b1b2b3b4", wr_addr[w0 + 1], wr_data[w0 + 1]); else pass_cnt++;
      total_cnt++; if (err_cnt - e0 != 0) $display("FAIL busy_start_error got %0d exp 0", err_cnt - e0); else pass_cnt++;
      start = 1'b1; load_len = 7'd1;
      @(negedge clk);
      start = 1'b0;
      total_cnt++; if (busy !== 1'b1 || byte_ready !== 1'b1) $display("FAIL b2b_start got busy=%b ready=%b exp 11", busy, byte_ready); else pass_cnt++;
      send_word(32'hC0FFEE01);
      byte_valid = 1'b0;
      for (int i = 0; i < 30 && done !== 1'b1; i++) @(negedge clk);
      total_cnt++; if (done !== 1'b1) $display("FAIL b2b_done got %b exp 1", done); else pass_cnt++;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_load();
      int w0 = wr_cnt;
      int d0 = done_cnt;
      start = 1'b1; load_len = 7'd2;
      @(negedge clk);
      start = 1'b0;
      send_word(32'hD0D1D2D3);
      send_word(32'hE0E1E2E3);
      byte_valid = 1'b0;
      total_cnt++; if (imem_we !== 1'b1 || imem_addr !== 32'h4) $display("FAIL mid_write got we=%b a=%h exp 1/4", imem_we, imem_addr); else pass_cnt++;
      reset = 1'b1;
      @(negedge clk);
      total_cnt++; if (imem_we !== 1'b0 || busy !== 1'b0 || byte_ready !== 1'b0)
         $display("FAIL mid_idle got we=%b busy=%b ready=%b exp 000", imem_we, busy, byte_ready); else pass_cnt++;
      total_cnt++; if (imem_addr !== 32'h0 || imem_wdata !== 32'h0) $display("FAIL mid_regs got a=%h d=%h exp 0/0", imem_addr, imem_wdata); else pass_cnt++;
      total_cnt++; if (cpu_reset !== 1'b1) $display("FAIL mid_cpu_reset got %b exp 1", cpu_reset); else pass_cnt++;
      reset = 1'b0;
      @(negedge clk);
      total_cnt++; if (nb_cpu_reset !== 1'b0 || cpu_reset !== 1'b1) $display("FAIL mid_release got nb=%b hold=%b exp 01", nb_cpu_reset, cpu_reset); else pass_cnt++;
      repeat (5) @(negedge clk);
      total_cnt++; if (wr_cnt - w0 != 2) $display("FAIL mid_writes got %0d exp 2", wr_cnt - w0); else pass_cnt++;
      total_cnt++; if (done_cnt - d0 != 0) $display("FAIL mid_done got %0d exp 0", done_cnt - d0); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_illegal_len();
      test_two_words();
      test_valid_gaps();
      test_abort();
      test_back_to_back();
      test_reset_mid_load();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
